// File: rtl/stamped_show_ahead_fifo_if.sv
// -----------------------------------------------------------------------------
// stamped_show_ahead_fifo_if
// Groups the request-queue handshake and the timestamp counter of
// stamped_show_ahead_fifo into one bundle.
//   master : producer/consumer side. Drives increment, wrreq, data and rdreq.
//            Observes count, full, q, empty and counter.
//   slave  : the FIFO itself, with the opposite directions.
// -----------------------------------------------------------------------------
interface stamped_show_ahead_fifo_if #(
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 9
);
    logic                 increment;
    logic [63:0]          count;
    logic                 wrreq;
    logic [WIDTH-1:0]     data;
    logic                 full;
    logic                 rdreq;
    logic [WIDTH-1:0]     q;
    logic                 empty;
    logic [LOG_DEPTH:0]   counter;

    modport master (
        output increment, wrreq, data, rdreq,
        input  count, full, q, empty, counter
    );

    modport slave (
        input  increment, wrreq, data, rdreq,
        output count, full, q, empty, counter
    );
endinterface

// File: rtl/stamped_show_ahead_fifo.sv
// -----------------------------------------------------------------------------
// stamped_show_ahead_fifo
// Single-clock show-ahead (first-word-fall-through) FIFO, bundled with a
// free-running 64-bit timestamp counter.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : stamped_show_ahead_fifo_if.slave
//          increment/count : timestamp advance request and current value
//          wrreq/data/full : enqueue side
//          rdreq/q/empty   : dequeue side (q shows the oldest entry)
//          counter         : occupancy, 0..DEPTH
// USE_SOFT selects register-array storage (1) or block-RAM storage with a
// registered read and a write-bypass register (0). The two are cycle-identical
// at the ports whenever the FIFO is non-empty.
// -----------------------------------------------------------------------------
module stamped_show_ahead_fifo #(
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 9,
    parameter bit USE_SOFT  = 1'b0
) (
    input logic                      clk,
    input logic                      rst,
    stamped_show_ahead_fifo_if.slave bus
);
    localparam int                 DEPTH   = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] DEPTH_C = (LOG_DEPTH + 1)'(DEPTH);

    logic [63:0]          count_q, count_d;
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   counter_q, counter_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 wr_acc_s, rd_acc_s, mem_we_s;

    // Next-state logic for the timestamp, pointers, occupancy and flags.
    always_comb begin
        wr_acc_s = bus.wrreq & ~full_q;
        rd_acc_s = bus.rdreq & ~empty_q;
        mem_we_s = wr_acc_s & ~rst;

        if (bus.increment) begin
            count_d = count_q + 64'd1;
        end else begin
            count_d = count_q;
        end

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   counter_d = counter_q + (LOG_DEPTH + 1)'(1);
            2'b01:   counter_d = counter_q - (LOG_DEPTH + 1)'(1);
            default: counter_d = counter_q;
        endcase

        empty_d = (counter_d == (LOG_DEPTH + 1)'(0));
        full_d  = (counter_d == DEPTH_C);
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 64'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            counter_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            counter_q <= counter_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.counter = counter_q;
    assign bus.empty   = empty_q;
    assign bus.full    = full_q;

    generate
        if (USE_SOFT) begin : g_soft
            logic [WIDTH-1:0] mem_q [DEPTH];

            // Register-array storage; contents survive reset.
            always_ff @(posedge clk) begin
                if (mem_we_s) begin
                    mem_q[wr_ptr_q] <= bus.data;
                end
            end

            assign bus.q = mem_q[rd_ptr_q];
        end else begin : g_ram
            logic [WIDTH-1:0]     ram_q [DEPTH];
            logic [WIDTH-1:0]     ram_dout_q;
            logic [WIDTH-1:0]     byp_data_q;
            logic                 byp_sel_q, byp_sel_d;
            logic [LOG_DEPTH-1:0] rd_addr_s;

            // The RAM is read at the *next* head address so that its
            // registered output is the head on the following cycle. When the
            // slot being written is that same next head (write into an
            // empty or one-entry-draining FIFO), the RAM would return stale
            // data, so the incoming word is captured and selected instead.
            always_comb begin
                if (rst) begin
                    rd_addr_s = '0;
                end else begin
                    rd_addr_s = rd_ptr_d;
                end
                byp_sel_d = mem_we_s & (wr_ptr_q == rd_addr_s);
            end

            // Synchronous-write, synchronous-read RAM; contents survive reset.
            always_ff @(posedge clk) begin
                if (mem_we_s) begin
                    ram_q[wr_ptr_q] <= bus.data;
                end
                ram_dout_q <= ram_q[rd_addr_s];
            end

            // Write-bypass capture and its select flag.
            always_ff @(posedge clk) begin
                byp_data_q <= bus.data;
                if (rst) begin
                    byp_sel_q <= 1'b0;
                end else begin
                    byp_sel_q <= byp_sel_d;
                end
            end

            assign bus.q = byp_sel_q ? byp_data_q : ram_dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_stamped_show_ahead_fifo.sv
// -----------------------------------------------------------------------------
// tb_stamped_show_ahead_fifo
// Drives a soft-storage and a RAM-storage instance (both 4 entries deep) with
// identical stimulus and checks each against a queue-based reference model
// of the FIFO and timestamp counter after every clock edge.
// -----------------------------------------------------------------------------
module tb_stamped_show_ahead_fifo;
    localparam int W     = 8;
    localparam int LD    = 2;
    localparam int DEPTH = 1 << LD;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [W-1:0] mq [$];
    logic [63:0]  mcount;

    always #5 clk = ~clk;

    stamped_show_ahead_fifo_if #(.WIDTH(W), .LOG_DEPTH(LD)) bus_s ();
    stamped_show_ahead_fifo_if #(.WIDTH(W), .LOG_DEPTH(LD)) bus_r ();

    stamped_show_ahead_fifo #(.WIDTH(W), .LOG_DEPTH(LD), .USE_SOFT(1'b1)) dut_soft (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    stamped_show_ahead_fifo #(.WIDTH(W), .LOG_DEPTH(LD), .USE_SOFT(1'b0)) dut_ram (
        .clk (clk),
        .rst (rst),
        .bus (bus_r)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("soft_count",   bus_s.count,          mcount);
        chk("soft_counter", 64'(bus_s.counter),   64'(mq.size()));
        chk("soft_empty",   64'(bus_s.empty),     64'(mq.size() == 0));
        chk("soft_full",    64'(bus_s.full),      64'(mq.size() == DEPTH));
        chk("ram_count",    bus_r.count,          mcount);
        chk("ram_counter",  64'(bus_r.counter),   64'(mq.size()));
        chk("ram_empty",    64'(bus_r.empty),     64'(mq.size() == 0));
        chk("ram_full",     64'(bus_r.full),      64'(mq.size() == DEPTH));
        if (mq.size() != 0) begin
            chk("soft_q", 64'(bus_s.q), 64'(mq[0]));
            chk("ram_q",  64'(bus_r.q), 64'(mq[0]));
        end
    endtask

    // One clock cycle: drive inputs, advance the model by the FIFO rules, check.
    task automatic step(input logic wr, input logic [W-1:0] d, input logic rd,
                        input logic inc, input logic rs);
        logic wa, ra;
        @(negedge clk);
        bus_s.wrreq = wr; bus_s.data = d; bus_s.rdreq = rd; bus_s.increment = inc;
        bus_r.wrreq = wr; bus_r.data = d; bus_r.rdreq = rd; bus_r.increment = inc;
        rst = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            mcount = 64'd0;
        end else begin
            wa = wr && (mq.size() < DEPTH);
            ra = rd && (mq.size() != 0);
            if (ra) void'(mq.pop_front());
            if (wa) mq.push_back(d);
            if (inc) mcount = mcount + 64'd1;
        end
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b1;
        mcount = 64'd0;
        bus_s.wrreq = 1'b0; bus_s.data = '0; bus_s.rdreq = 1'b0; bus_s.increment = 1'b0;
        bus_r.wrreq = 1'b0; bus_r.data = '0; bus_r.rdreq = 1'b0; bus_r.increment = 1'b0;

        // Reset state.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Timestamp: 5 increments then hold, then reset.
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("count_hold5", bus_s.count, 64'd5);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Timestamp wrap from a forced near-maximum value.
        @(negedge clk);
        force dut_soft.count_q = 64'hFFFF_FFFF_FFFF_FFFE;
        force dut_ram.count_q  = 64'hFFFF_FFFF_FFFF_FFFE;
        @(posedge clk);
        #1;
        release dut_soft.count_q;
        release dut_ram.count_q;
        mcount = 64'hFFFF_FFFF_FFFF_FFFE;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("count_wrapped", bus_r.count, 64'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Write into empty: rdreq in the write cycle is ignored, then pop.
        step(1'b1, 8'hA1, 1'b1, 1'b0, 1'b0);
        chk("a1_visible", 64'(bus_r.q), 64'hA1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Fill to full, rejected write with simultaneous read, drain.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        chk("full_set", 64'(bus_s.full), 64'd1);
        step(1'b1, 8'h14, 1'b1, 1'b0, 1'b0);
        chk("after_full_rd", 64'(bus_s.counter), 64'd3);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Sustained read+write at occupancy 2, pointers wrapping several times.
        step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h42 + i), 1'b1, 1'b1, 1'b0);
        chk("stream_counter", 64'(bus_r.counter), 64'd2);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation discards queued entries.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        chk("post_rst_q", 64'(bus_s.q), 64'h99);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stamped_show_ahead_fifo.md
Name: stamped_show_ahead_fifo

Overview:
- Single-clock, show-ahead (first-word-fall-through) FIFO for request queues between the DNN accelerator write path and the AMI memory interface.
- Bundled with a free-running 64-bit timestamp counter that stamps enqueued requests.
- Two storage styles, selectable by parameter: register array ("soft") or inferrable block RAM with a prefetch stage. Both are cycle-identical at the ports.

Parameters:
- WIDTH, 32, bit width of each FIFO entry.
- LOG_DEPTH, 9, log2 of capacity; DEPTH = 2**LOG_DEPTH entries.
- USE_SOFT, 0: 1 = register-array storage; 0 = RAM-inferred storage. Port behaviour is identical for both.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- increment  in  1  advance timestamp counter this cycle.
- count  out  64  timestamp counter value (registered).
- wrreq  in  1  enqueue request.
- data  in  WIDTH  entry to enqueue.
- full  out  1  FIFO holds DEPTH entries.
- rdreq  in  1  dequeue request (pops the entry currently on q).
- q  out  WIDTH  oldest entry (show-ahead).
- empty  out  1  FIFO holds zero entries.
- counter  out  LOG_DEPTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset, sampled at the clock edge while rst=1:
  - count=0, counter=0, empty=1, full=0, read/write pointers=0.
  - Storage contents are not cleared.
  - Reset mid-operation discards all queued entries from the next cycle.
- Timestamp counter:
  - count <= count+1 on each edge with increment=1 and rst=0; otherwise holds.
  - Wraps from 2^64-1 to 0.
  - Its first value after reset release is 0.
- Write accept = wrreq && !full. The entry is written at the edge; otherwise wrreq is ignored and data is dropped.
- Read accept = rdreq && !empty. It pops at the edge; otherwise rdreq is ignored.
- full is evaluated on the pre-edge state. A write while full is rejected even if a read is accepted in the same cycle.
- Simultaneous accepted read and write: occupancy unchanged, both pointers advance.
- Write into empty FIFO (no bypass):
  - The entry appears on q with empty=0 on the cycle after the write edge (1-cycle write-to-visible latency).
  - rdreq in the write cycle itself is ignored.
- Show-ahead output:
  - Whenever empty=0, q equals the oldest entry combinationally/registered such that no rdreq is needed to view it.
  - After an accepted read, q shows the next entry on the following cycle.
  - q is don't-care when empty=1.
- Order is strict FIFO.
- Pointers are LOG_DEPTH bits and wrap modulo DEPTH.
- Status flags:
  - empty = (counter==0), full = (counter==DEPTH), both registered state.
  - counter updates +1 on write-only, -1 on read-only, and is unchanged on both or neither.
- RAM style (USE_SOFT=0):
  - Uses a synchronous-read RAM plus an output holding register/prefetch.
  - Must reproduce the same q/empty timing as the soft style, including back-to-back reads at one per cycle.
- Sustained throughput: one write and one read per cycle indefinitely when neither full nor empty.

Test Plan:
- Reset then increment=1 for 5 cycles, then increment=0 for 3 cycles -> count reads 0,1,2,3,4,5 and holds at 5; assert rst -> count=0 next cycle.
- Preload count near wrap (2^64-2) via forced value, increment 3 cycles -> 2^64-1, 0, 1.
- Empty FIFO, write 0xA1 at cycle 0 -> cycle 1: empty=0, q=0xA1, counter=1; rdreq at cycle 1 -> cycle 2: empty=1, counter=0.
- LOG_DEPTH=2: write 0x10..0x13 -> full=1, counter=4; write 0x14 (with simultaneous rdreq) -> 0x14 dropped, 0x10 popped, counter=3; drain -> q shows 0x11,0x12,0x13, then empty=1.
- Continuous simultaneous read+write of incrementing values for 20 cycles at counter=2 -> counter stays 2, pointers wrap, output order matches input exactly; repeat with USE_SOFT=0 and 1, with identical traces.
- Fill 3 entries, assert rst for one cycle -> next cycle empty=1, full=0, counter=0; rdreq ignored; a new write appears on q one cycle later.
